// File: rtl/q2_pkg.sv
// q2 shared package: sequencer state codes, phase codes and the transition rule.
// The decoder bench imports this too, so keep the codes here and nowhere else.
// Contents: state_e (one code per major state), PH_A/PH_B, next_state().
package q2_pkg;

  // {s3,s2,s1,s0} codes for each major state.
  typedef enum logic [3:0] {
    ST_FETCH = 4'b0000,
    ST_DEREF = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_EXEC  = 4'b0011,
    ST_ALU1  = 4'b0100,
    ST_ALU2  = 4'b1000
  } state_e;

  // The phase bit drives ws directly: phase A has ws low, phase B has ws high.
  localparam logic PH_A = 1'b0;
  localparam logic PH_B = 1'b1;

  // Successor of a state at the end of its phase B. deref matters only
  // for FETCH and s2in only for EXEC. Any stray code falls back to FETCH.
  function automatic state_e next_state(input state_e cur,
                                        input logic   deref,
                                        input logic   s2in);
    case (cur)
      ST_FETCH: next_state = deref ? ST_DEREF : ST_LOAD;
      ST_DEREF: next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_EXEC;
      ST_EXEC:  next_state = s2in ? ST_ALU1 : ST_FETCH;
      ST_ALU1:  next_state = ST_ALU2;
      default:  next_state = ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/sw_sync.sv
// sw_sync: two-flop synchronizer for one asynchronous front-panel switch.
// Latency: a change on d shows up on q two rising edges of clk later.
// Ports: clk, rst (sync, active-high, clears both flops), d (async in), q (synced out).
module sw_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// state_sequencer: major-state sequencer with run/halt/single-step control.
// Each state lasts two clocks (phase A with ws=0, then phase B with ws=1).
// Halt is checked only on entry to FETCH phase A. All outputs come from flops.
// Ports: clk, rst (sync, active-high); run_sw, step_sw (async switches);
//        deref (sampled in FETCH phase B), s2in (sampled in EXEC phase B);
//        s0..s3 state bits, ns0..ns3 their flopped complements, ws, running.
module state_sequencer
  import q2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run_sw,
  input  logic step_sw,
  input  logic deref,
  input  logic s2in,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ns0,
  output logic ns1,
  output logic ns2,
  output logic ns3,
  output logic ws,
  output logic running
);

  logic run_sync;
  logic step_sync;

  sw_sync u_run_sync (
    .clk (clk),
    .rst (rst),
    .d   (run_sw),
    .q   (run_sync)
  );

  sw_sync u_step_sync (
    .clk (clk),
    .rst (rst),
    .d   (step_sw),
    .q   (step_sync)
  );

  state_e     state_q, state_n;
  logic [3:0] ns_q;
  logic       phase_q, phase_n;
  logic       running_q, running_n;
  logic       step_pend_q, step_pend_n;
  logic       step_prev_q;
  logic       step_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      ns_q        <= 4'hF;
      phase_q     <= PH_A;
      running_q   <= 1'b0;
      step_pend_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      // The complement gets its own flops so ns never lags or glitches vs s.
      ns_q        <= ~state_n;
      phase_q     <= phase_n;
      running_q   <= running_n;
      step_pend_q <= step_pend_n;
      step_prev_q <= step_sync;
    end
  end

  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    running_n   = running_q;
    step_pend_n = step_pend_q;
    step_rise   = step_sync & ~step_prev_q;

    if (!running_q) begin
      // Halted: parked in FETCH phase A. Run wins over a simultaneous step,
      // and the restart cycle itself stays in phase A.
      if (run_sync) begin
        running_n   = 1'b1;
        step_pend_n = 1'b0;
      end else if (step_rise) begin
        running_n   = 1'b1;
        step_pend_n = 1'b1;
      end
    end else if (phase_q == PH_A) begin
      phase_n = PH_B;
    end else begin
      phase_n = PH_A;
      state_n = next_state(state_q, deref, s2in);
      // Instruction boundary: a finished step is consumed here, and the
      // run switch alone decides whether the next instruction starts.
      if (state_n == ST_FETCH) begin
        running_n   = run_sync;
        step_pend_n = 1'b0;
      end
    end
  end

  logic [3:0] s_bits;
  assign s_bits  = state_q;

  assign s0      = s_bits[0];
  assign s1      = s_bits[1];
  assign s2      = s_bits[2];
  assign s3      = s_bits[3];
  assign ns0     = ns_q[0];
  assign ns1     = ns_q[1];
  assign ns2     = ns_q[2];
  assign ns3     = ns_q[3];
  assign ws      = phase_q;
  assign running = running_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_state_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_sw = 1'b0, step_sw = 1'b0, deref = 1'b0, s2in = 1'b0;
  logic s0, s1, s2, s3, ns0, ns1, ns2, ns3, ws, running;

  state_sequencer dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_sw(step_sw),
    .deref(deref), .s2in(s2in),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .ns0(ns0), .ns1(ns1), .ns2(ns2), .ns3(ns3),
    .ws(ws), .running(running)
  );

  always #5 clk = ~clk;

  logic [3:0] s_cur, ns_cur;
  assign s_cur  = {s3, s2, s1, s0};
  assign ns_cur = {ns3, ns2, ns1, ns0};

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // State codes: FETCH 0, DEREF 1, LOAD 2, EXEC 3, ALU1 4, ALU2 8.
  function automatic logic [3:0] succ(input logic [3:0] st, input logic dr, input logic sa);
    case (st)
      4'd0:    return dr ? 4'd1 : 4'd2;
      4'd1:    return 4'd2;
      4'd2:    return 4'd3;
      4'd3:    return sa ? 4'd4 : 4'd0;
      4'd4:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  logic [3:0] m_state = 4'd0;
  logic m_ph = 1'b0, m_run = 1'b0;
  logic r1 = 1'b0, r2 = 1'b0, t1 = 1'b0, t2 = 1'b0, tp = 1'b0;
  logic m_rs, m_rise;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 4'd0; m_ph = 1'b0; m_run = 1'b0;
      r1 = 1'b0; r2 = 1'b0; t1 = 1'b0; t2 = 1'b0; tp = 1'b0;
    end else begin
      m_rs   = r2;
      m_rise = t2 & ~tp;
      if (!m_run) begin
        if (m_rs || m_rise) m_run = 1'b1;
      end else if (!m_ph) begin
        m_ph = 1'b1;
      end else begin
        m_ph    = 1'b0;
        m_state = succ(m_state, deref, s2in);
        if (m_state == 4'd0) m_run = m_rs;
      end
      tp = t2; r2 = r1; r1 = run_sw; t2 = t1; t1 = step_sw;
    end
  end

  // One clock; outputs compared against the model at the falling edge.
  task automatic tick();
    logic [3:0] inv;
    @(negedge clk);
    inv = ~s_cur;
    chk("state", int'(s_cur), int'(m_state));
    chk("ns", int'(ns_cur), int'(4'hF ^ m_state));
    chk("ws", int'(ws), int'(m_ph));
    chk("running", int'(running), int'(m_run));
    chk("ns_inv", int'(ns_cur), int'(inv));
  endtask

  task automatic wait_state(input logic [3:0] st, input logic w, input string nm);
    int n = 0;
    while (!(s_cur == st && ws == w) && n < 80) begin tick(); n++; end
    chk(nm, int'(s_cur == st && ws == w), 1);
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    while (running && n < 80) begin tick(); n++; end
    chk(nm, int'(running), 0);
  endtask

  int n, k, fb, rc, bad, seen;
  logic [4:0] exp2 [8];
  logic [3:0] exp3 [6];
  logic [3:0] got3 [6];

  initial begin
    exp2 = '{5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd0, 5'd1, 5'd4};
    exp3 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd0};

    // Reset for 3 cycles, then idle 10 cycles with run off.
    repeat (3) tick();
    chk("rst_s", int'(s_cur), 0);
    chk("rst_ns", int'(ns_cur), 15);
    chk("rst_ws", int'(ws), 0);
    chk("rst_running", int'(running), 0);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin tick(); if (s_cur != 0 || ws || running || ns_cur != 4'hF) bad++; end
    chk("idle_hold", bad, 0);

    // Direct instruction: restart latency, then exact state/ws trace.
    run_sw = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!running && n < 20);
    chk("restart_latency", n, 3);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("direct_trace", int'({s_cur, ws}), int'(exp2[i]));
    end

    // Indirect + ALU: 12 clocks from one FETCH phase B to the next.
    deref = 1'b1; s2in = 1'b1;
    wait_state(4'd0, 1'b1, "wait_fetch_b");
    n = 0; k = 0;
    do begin
      tick(); n++;
      if (ws && k < 6) begin got3[k] = s_cur; k++; end
    end while (!(s_cur == 4'd0 && ws) && n < 40);
    chk("indirect_len", n, 12);
    for (int i = 0; i < 6; i++) chk("indirect_seq", int'(got3[i]), int'(exp3[i]));

    // Stop during LOAD phase A: EXEC still completes, then halt.
    deref = 1'b0; s2in = 1'b0;
    wait_state(4'd2, 1'b0, "wait_load_a");
    run_sw = 1'b0;
    seen = 0; n = 0;
    while (running && n < 40) begin
      tick(); n++;
      if (s_cur == 4'd3 && ws) seen = 1;
    end
    chk("stop_exec_done", seen, 1);
    chk("stop_halted", int'(running), 0);
    chk("stop_at_fetch_a", int'({s_cur, ws}), 0);
    bad = 0;
    repeat (10) begin tick(); if (s_cur != 0 || ws || running) bad++; end
    chk("stop_hold", bad, 0);

    // Single step, 5-cycle pulse, direct instruction: 6 running clocks.
    step_sw = 1'b1;
    fb = 0; rc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) step_sw = 1'b0;
      tick();
      if (running) rc++;
      if (s_cur == 4'd0 && ws) fb++;
    end
    chk("step1_fetches", fb, 1);
    chk("step1_clocks", rc, 6);
    chk("step1_halt", int'({s_cur, ws, running}), 0);

    // Second step, held high 30 cycles, indirect + ALU: one instruction only.
    deref = 1'b1; s2in = 1'b1;
    step_sw = 1'b1;
    fb = 0; rc = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 30) step_sw = 1'b0;
      tick();
      if (running) rc++;
      if (s_cur == 4'd0 && ws) fb++;
    end
    chk("step2_fetches", fb, 1);
    chk("step2_clocks", rc, 12);
    chk("step2_halt", int'({s_cur, ws, running}), 0);

    // Run and step together while halted: behaves as run, no leftover step.
    deref = 1'b0; s2in = 1'b0;
    run_sw = 1'b1; step_sw = 1'b1;
    fb = 0;
    repeat (30) begin tick(); if (s_cur == 4'd0 && ws) fb++; end
    chk("run_step_runs", int'(fb >= 2), 1);
    run_sw = 1'b0; step_sw = 1'b0;
    wait_halt("run_step_halt");
    bad = 0;
    repeat (20) begin tick(); if (running) bad++; end
    chk("run_step_no_extra", bad, 0);

    // Reset during ALU1.
    run_sw = 1'b1; s2in = 1'b1;
    wait_state(4'd4, 1'b0, "wait_alu1");
    rst = 1'b1;
    tick();
    chk("midrst_s", int'(s_cur), 0);
    chk("midrst_ns", int'(ns_cur), 15);
    chk("midrst_running", int'(running), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_halted", int'({s_cur, ws, running}), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) run_sw = ~run_sw;
      if ($urandom_range(7) == 0) step_sw = ~step_sw;
      deref = 1'($urandom_range(1));
      s2in  = 1'($urandom_range(1));
      rst   = ($urandom_range(299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
